// File: rtl/mips_sevenseg_scan_if.sv
// Display-side signal bundle for mips_sevenseg_scan: value/enable in, segment/anode pins out.
interface mips_sevenseg_scan_if;
  logic [15:0] test_value;
  logic        disp_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output test_value, disp_en,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  test_value, disp_en,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/mips_sevenseg_scan.sv
// 4-digit multiplexed hex display for the MIPS test_value bus; the value is
// snapshotted once per scan frame so a frame never mixes old and new data.
module mips_sevenseg_scan #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          LZ_BLANK       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  mips_sevenseg_scan_if.slave  bus
);

  localparam int unsigned         CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]          SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]          AN_OFF   = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  digit_e           dig_q, dig_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [15:0]      snap_q, snap_d;
  logic             tick_q, tick_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             div_last;
  logic             wrap;
  logic [3:0]       nibble;
  logic [6:0]       pattern;
  logic             blank;
  logic [3:0]       onehot;

  // Active-high gfedcba patterns for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Refresh divider, digit sequencer and per-frame snapshot.
  always_comb begin
    div_last = (div_q == CNT_LAST);
    div_d    = div_last ? '0 : div_q + CNT_W'(1);
    dig_d    = dig_q;
    if (div_last) begin
      case (dig_q)
        DIG0:    dig_d = DIG1;
        DIG1:    dig_d = DIG2;
        DIG2:    dig_d = DIG3;
        default: dig_d = DIG0;
      endcase
    end
    wrap   = div_last && (dig_q == DIG3);
    snap_d = wrap ? bus.test_value : snap_q;
    tick_d = wrap;
  end

  // Digit decode and leading-zero blanking from the current digit and snapshot.
  always_comb begin
    nibble = snap_q[3:0];
    blank  = 1'b0;
    case (dig_q)
      DIG0: begin
        nibble = snap_q[3:0];
        blank  = 1'b0;
      end
      DIG1: begin
        nibble = snap_q[7:4];
        blank  = LZ_BLANK && (snap_q[15:4] == '0);
      end
      DIG2: begin
        nibble = snap_q[11:8];
        blank  = LZ_BLANK && (snap_q[15:8] == '0);
      end
      default: begin
        nibble = snap_q[15:12];
        blank  = LZ_BLANK && (snap_q[15:12] == '0);
      end
    endcase
    pattern = hex_to_seg(nibble);
    onehot  = 4'b0001 << dig_q;

    // A blanked digit keeps its anode off; disp_en only gates the anodes.
    if (!bus.disp_en || blank) begin
      an_d = AN_OFF;
    end else begin
      an_d = SEG_ACTIVE_LOW ? ~onehot : onehot;
    end

    if (blank) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      dig_q  <= DIG0;
      snap_q <= '0;
      tick_q <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      div_q  <= div_d;
      dig_q  <= dig_d;
      snap_q <= snap_d;
      tick_q <= tick_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = SEG_ACTIVE_LOW;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_mips_sevenseg_scan.sv
// Directed bench for mips_sevenseg_scan: two instances (leading-zero blanking on/off),
// REFRESH_DIV=4, active-low pins, so one scan frame is 16 clocks.
module tb_mips_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] test_value;
  logic        disp_en;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mips_sevenseg_scan_if bus0 ();
  mips_sevenseg_scan_if bus1 ();

  assign bus0.test_value = test_value;
  assign bus0.disp_en    = disp_en;
  assign bus1.test_value = test_value;
  assign bus1.disp_en    = disp_en;

  mips_sevenseg_scan #(
    .REFRESH_DIV   (4),
    .LZ_BLANK      (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut0 (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus0)
  );

  mips_sevenseg_scan #(
    .REFRESH_DIV   (4),
    .LZ_BLANK      (1'b0),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut1 (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus1)
  );

  // Tables are written {digit3, digit2, digit1, digit0}.
  localparam logic [3:0][3:0] AN_WALK     = {4'h7, 4'hB, 4'hD, 4'hE};
  localparam logic [3:0][3:0] AN_D0       = {4'hF, 4'hF, 4'hF, 4'hE};
  localparam logic [3:0][6:0] SEG_0_LZ    = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [3:0][6:0] SEG_0000    = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [3:0][6:0] SEG_1A3F    = {7'h79, 7'h08, 7'h30, 7'h0E};
  localparam logic [3:0][6:0] SEG_5_LZ    = {7'h7F, 7'h7F, 7'h7F, 7'h12};
  localparam logic [3:0][6:0] SEG_0005    = {7'h40, 7'h40, 7'h40, 7'h12};
  localparam logic [3:0][6:0] SEG_1111    = {7'h79, 7'h79, 7'h79, 7'h79};
  localparam logic [3:0][6:0] SEG_2222    = {7'h24, 7'h24, 7'h24, 7'h24};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs n_ticks clocks of a frame that starts on the edge after a wrap, checking
  // both instances every cycle; optional input changes happen right after a tick's checks.
  task automatic run_frame(
    input string           tag,
    input logic [3:0][3:0] an0,
    input logic [3:0][6:0] seg0,
    input logic [3:0][3:0] an1,
    input logic [3:0][6:0] seg1,
    input int              n_ticks,
    input int              chg_at,
    input logic [15:0]     chg_val,
    input int              off_at,
    input int              on_at
  );
    for (int t = 1; t <= n_ticks; t++) begin
      int d;
      @(posedge clk);
      #1;
      d = (t - 1) / 4;
      check_eq($sformatf("%s.t%0d.an0", tag, t),  32'(bus0.an),  disp_en ? 32'(an0[d]) : 32'hF);
      check_eq($sformatf("%s.t%0d.seg0", tag, t), 32'(bus0.seg), 32'(seg0[d]));
      check_eq($sformatf("%s.t%0d.an1", tag, t),  32'(bus1.an),  disp_en ? 32'(an1[d]) : 32'hF);
      check_eq($sformatf("%s.t%0d.seg1", tag, t), 32'(bus1.seg), 32'(seg1[d]));
      check_eq($sformatf("%s.t%0d.tick", tag, t), 32'(bus0.frame_tick), (t == 16) ? 32'd1 : 32'd0);
      if (t == chg_at) test_value = chg_val;
      if (t == off_at) disp_en = 1'b0;
      if (t == on_at)  disp_en = 1'b1;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".an0"},  32'(bus0.an),  32'hF);
    check_eq({tag, ".seg0"}, 32'(bus0.seg), 32'h7F);
    check_eq({tag, ".dp0"},  32'(bus0.dp),  32'h1);
    check_eq({tag, ".tick"}, 32'(bus0.frame_tick), 32'h0);
    check_eq({tag, ".an1"},  32'(bus1.an),  32'hF);
    check_eq({tag, ".seg1"}, 32'(bus1.seg), 32'h7F);
  endtask

  initial begin
    rst_n      = 1'b0;
    test_value = 16'h0000;
    disp_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");

    rst_n = 1'b1;
    #2;
    check_eq("release.an0", 32'(bus0.an), 32'hF);
    test_value = 16'h1A3F;

    // First frame shows the reset snapshot, not the live 1A3F.
    run_frame("f0", AN_D0, SEG_0_LZ, AN_WALK, SEG_0000, 16, 0, 16'h0, 0, 0);
    run_frame("f1", AN_WALK, SEG_1A3F, AN_WALK, SEG_1A3F, 16, 1, 16'h0005, 0, 0);
    run_frame("f2", AN_D0, SEG_5_LZ, AN_WALK, SEG_0005, 16, 1, 16'h1111, 0, 0);
    // 2222 arrives mid-frame and must not appear until the next wrap.
    run_frame("f3", AN_WALK, SEG_1111, AN_WALK, SEG_1111, 16, 8, 16'h2222, 0, 0);
    run_frame("f4", AN_WALK, SEG_2222, AN_WALK, SEG_2222, 16, 0, 16'h0, 2, 12);
    check_eq("f4.dp0", 32'(bus0.dp), 32'h1);
    run_frame("f5", AN_WALK, SEG_2222, AN_WALK, SEG_2222, 10, 0, 16'h0, 0, 0);

    // Asynchronous reset while digit 2 is lit.
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    @(posedge clk);
    #1;
    check_idle("midrst.hold");
    rst_n = 1'b1;

    run_frame("f6", AN_D0, SEG_0_LZ, AN_WALK, SEG_0000, 16, 0, 16'h0, 0, 0);
    run_frame("f7", AN_WALK, SEG_2222, AN_WALK, SEG_2222, 16, 0, 16'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
